// File: rtl/ccff_loader_pkg.sv
// Shared types and word-geometry helpers for the configuration-chain loader.
// No logic of its own; latency and backpressure are defined by the users.
package ccff_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SHIFT,
        PUSH,
        FIN
    } state_t;

    // Number of words needed to cover a chain of len bits.
    function automatic int nwords(input int len, input int w);
        return (len + w - 1) / w;
    endfunction

    // Bits actually used from the final word; its upper bits are discarded.
    function automatic int last_bits(input int len, input int w);
        return len - (nwords(len, w) - 1) * w;
    endfunction

endpackage

// File: rtl/ccff_word_shifter.sv
// Word serialiser (LSB first) plus indexed capture register for the returning bits.
// One bit per shift cycle; no backpressure of its own, the parent gates shift.
module ccff_word_shifter #(
    parameter int WORD_W = 32,
    parameter int IDX_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              shift,
    input  logic              clear,
    input  logic [WORD_W-1:0] din,
    output logic              ser_out,
    input  logic              ser_in,
    output logic [WORD_W-1:0] par_out,
    output logic [IDX_W-1:0]  idx
);

    logic [WORD_W-1:0] sh_q;
    logic [WORD_W-1:0] cap_q;
    logic [IDX_W-1:0]  idx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q <= '0;
        end else if (load) begin
            sh_q <= din;
        end else if (shift) begin
            sh_q <= {1'b0, sh_q[WORD_W-1:1]};
        end
    end

    // Capture starts from zero each word so a short final word reads back zero-extended.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_q <= '0;
            idx_q <= '0;
        end else if (load || clear) begin
            cap_q <= '0;
            idx_q <= '0;
        end else if (shift) begin
            cap_q[idx_q] <= ser_in;
            idx_q        <= idx_q + IDX_W'(1);
        end
    end

    assign ser_out = sh_q[0];
    assign par_out = cap_q;
    assign idx     = idx_q;

endmodule

// File: rtl/ccff_chain_loader.sv
// Loads the ccff chain from a word stream and returns the displaced bits as readback words.
// Latency: start->first shift 2 cycles; a full rb holding register stalls the chain in PUSH.
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter  int WORD_W    = 32,
    parameter  int CHAIN_LEN = 58,
    localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              pReset_n,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [WORD_W-1:0] cfg_data,
    output logic              rb_valid,
    input  logic              rb_ready,
    output logic [WORD_W-1:0] rb_data,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              shift_en
);

    localparam int NW     = nwords(CHAIN_LEN, WORD_W);
    localparam int LAST_W = last_bits(CHAIN_LEN, WORD_W);
    localparam int IDX_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    localparam logic [CNT_W-1:0] LAST_START = CNT_W'((NW - 1) * WORD_W);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(CHAIN_LEN);
    localparam logic [IDX_W-1:0] FULL_IDX   = IDX_W'(WORD_W - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(LAST_W - 1);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  bit_cnt;
    logic [IDX_W-1:0]  rb_idx;
    logic [WORD_W-1:0] rb_shreg;
    logic              ser_bit;
    logic              start_go;
    logic              abort_go;
    logic              rb_free;
    logic              push_go;
    logic              sh_load;
    logic              sh_shift;
    logic              word_end;

    assign start_go = (state == IDLE) & start & ~abort;
    assign abort_go = abort & (state != IDLE);
    assign rb_free  = ~rb_valid | rb_ready;
    assign push_go  = (state == PUSH) & rb_free & ~abort;
    assign sh_load  = (state == FETCH) & cfg_valid & ~abort;
    assign sh_shift = (state == SHIFT);

    // The final word is recognised by where bit_cnt stands, not by a word counter.
    assign word_end = (rb_idx == ((bit_cnt >= LAST_START) ? LAST_IDX : FULL_IDX));

    ccff_word_shifter #(
        .WORD_W (WORD_W),
        .IDX_W  (IDX_W)
    ) u_shifter (
        .clk     (prog_clk),
        .rst_n   (pReset_n),
        .load    (sh_load),
        .shift   (sh_shift),
        .clear   (push_go),
        .din     (cfg_data),
        .ser_out (ser_bit),
        .ser_in  (ccff_tail),
        .par_out (rb_shreg),
        .idx     (rb_idx)
    );

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)     state_nxt = FETCH;
            FETCH:   if (cfg_valid) state_nxt = SHIFT;
            SHIFT:   if (word_end)  state_nxt = PUSH;
            PUSH:    if (rb_free)   state_nxt = (bit_cnt < CNT_MAX) ? FETCH : FIN;
            FIN:     if (!rb_valid) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
        if (abort) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            bit_cnt <= '0;
            err     <= 1'b0;
        end else begin
            if (start_go) begin
                bit_cnt <= '0;
            end else if (sh_shift && (bit_cnt != CNT_MAX)) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
            if (abort) begin
                err <= 1'b1;
            end else if (start_go) begin
                err <= 1'b0;
            end
        end
    end

    // Readback holding register: an abort drops any undelivered word.
    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            rb_valid <= 1'b0;
            rb_data  <= '0;
        end else begin
            if (abort_go) begin
                rb_valid <= 1'b0;
            end else if (push_go) begin
                rb_valid <= 1'b1;
            end else if (rb_ready) begin
                rb_valid <= 1'b0;
            end
            if (push_go) begin
                rb_data <= rb_shreg;
            end
        end
    end

    assign busy      = (state != IDLE);
    assign cfg_ready = (state == FETCH);
    assign shift_en  = sh_shift;
    assign ccff_head = sh_shift & ser_bit;
    assign done      = (state == FIN) & ~rb_valid & ~abort;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: 58-bit chain model on the serial pins, readback scoreboard.
module tb_ccff_chain_loader;

    logic        prog_clk  = 1'b0;
    logic        pReset_n  = 1'b0;
    logic        start     = 1'b0;
    logic        abort     = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [31:0] cfg_data  = '0;
    logic        rb_ready  = 1'b1;
    logic        busy, done, err, cfg_ready, rb_valid, ccff_head, ccff_tail, shift_en;
    logic [31:0] rb_data;

    logic [57:0] chain;
    logic [57:0] chain_init = '0;
    logic        chain_load = 1'b0;
    logic [31:0] exp_rb;
    logic [31:0] rbq[$];

    int total = 0;
    int bad   = 0;
    int sh_cnt = 0;
    int done_cnt = 0;
    int cyc = 0;
    int sh_mark = 0;
    int first_sh_cyc = 0;
    int start_cyc = 0;
    bit aborted = 1'b0;

    localparam logic [57:0] PRELOAD = 58'h2AA_AAAA_AAAA_AAAA;

    always #5 prog_clk = ~prog_clk;

    ccff_chain_loader #(.WORD_W(32), .CHAIN_LEN(58)) dut (
        .prog_clk  (prog_clk),
        .pReset_n  (pReset_n),
        .start     (start),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_data  (cfg_data),
        .rb_valid  (rb_valid),
        .rb_ready  (rb_ready),
        .rb_data   (rb_data),
        .ccff_head (ccff_head),
        .ccff_tail (ccff_tail),
        .shift_en  (shift_en)
    );

    // Chain model: head enters at bit 57, tail leaves from bit 0.
    assign ccff_tail = chain[0];
    always @(posedge prog_clk) begin
        cyc <= cyc + 1;
        if (chain_load) chain <= chain_init;
        else if (shift_en) chain <= {ccff_head, chain[57:1]};
    end

    always @(negedge prog_clk) begin
        if (shift_en) begin
            if (sh_cnt == sh_mark) first_sh_cyc = cyc;
            sh_cnt++;
        end
        if (done) done_cnt++;
        if (rb_valid && rb_ready) begin
            total++;
            if (rbq.size() == 0) begin
                bad++;
                $display("FAIL rb_unexpected got=%h want=none", rb_data);
            end else begin
                exp_rb = rbq.pop_front();
                if (rb_data !== exp_rb) begin
                    bad++;
                    $display("FAIL rb_word got=%h want=%h", rb_data, exp_rb);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic preload_chain(input logic [57:0] v);
        chain_init = v;
        chain_load = 1'b1;
        @(posedge prog_clk); #1;
        chain_load = 1'b0;
    endtask

    task automatic expect_from_chain();
        logic [57:0] c;
        c = chain;
        rbq.push_back(c[31:0]);
        rbq.push_back({6'b0, c[57:32]});
    endtask

    // Stimulus driver only: one load with optional cfg gap, rb backpressure or abort.
    task automatic do_load(input logic [31:0] w0, input logic [31:0] w1, input int gap,
                           input int hold, input int abort_at,
                           output int gap_bad, output int hold_sh, output bit tmo);
        int done_base;
        int n;
        done_base = done_cnt;
        gap_bad = 0; hold_sh = 0; tmo = 1'b0; aborted = 1'b0;
        sh_mark = sh_cnt;
        start_cyc = cyc;
        fork
            begin
                int m;
                start = 1'b1; cfg_valid = 1'b1; cfg_data = w0;
                @(posedge prog_clk); #1;
                start = 1'b0;
                for (int k = 0; k < 2; k++) begin
                    if (k == 1) begin
                        cfg_data = w1;
                        cfg_valid = (gap == 0);
                        if (gap > 0) begin
                            m = 0;
                            do begin @(negedge prog_clk); m++; end
                            while (!cfg_ready && !aborted && m < 300);
                            for (int g = 1; g < gap; g++) begin
                                @(negedge prog_clk);
                                if (shift_en || !cfg_ready) gap_bad++;
                            end
                            @(posedge prog_clk); #1;
                            cfg_valid = 1'b1;
                        end
                    end
                    m = 0;
                    @(negedge prog_clk);
                    while (!cfg_ready && !aborted && m < 300) begin @(negedge prog_clk); m++; end
                    if (m >= 300) tmo = 1'b1;
                    @(posedge prog_clk); #1;
                    cfg_valid = 1'b0;
                    if (aborted) break;
                end
            end
            begin
                int m;
                if (hold > 0) begin
                    rb_ready = 1'b0;
                    m = 0;
                    @(negedge prog_clk);
                    while (!rb_valid && m < 300) begin @(negedge prog_clk); m++; end
                    if (m >= 300) tmo = 1'b1;
                    repeat (hold) begin
                        @(negedge prog_clk);
                        if (shift_en) hold_sh++;
                    end
                    @(posedge prog_clk); #1;
                    rb_ready = 1'b1;
                end
            end
            begin
                int m, guard;
                if (abort_at > 0) begin
                    m = 0; guard = 0;
                    while (m < abort_at && guard < 500) begin
                        @(negedge prog_clk); guard++;
                        if (shift_en) m++;
                    end
                    abort = 1'b1; aborted = 1'b1;
                    @(posedge prog_clk); #1;
                    abort = 1'b0;
                end
            end
        join
        n = 0;
        while (done_cnt == done_base && !aborted && n < 400) begin @(posedge prog_clk); #1; n++; end
        if (n >= 400) tmo = 1'b1;
        @(posedge prog_clk); #1;
    endtask

    task automatic test_reset();
        #12;
        total++;
        if ({busy, done, err, cfg_ready, rb_valid, ccff_head, shift_en} !== 7'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b want=0000000",
                     {busy, done, err, cfg_ready, rb_valid, ccff_head, shift_en});
        end
        total++;
        if (rb_data !== 32'h0) begin bad++; $display("FAIL reset_rb_data got=%h want=0", rb_data); end
        @(posedge prog_clk); #1;
        pReset_n = 1'b1;
        @(posedge prog_clk); #1;
    endtask

    task automatic test_basic_load();
        logic [31:0] w0, w1;
        logic [57:0] want;
        int sh0, d0, gb, hs;
        bit tmo;
        w0 = 32'hDEADBEEF; w1 = 32'h0155_1234;
        want = {w1[25:0], w0};
        preload_chain(PRELOAD);
        rbq.push_back(32'hAAAAAAAA);
        rbq.push_back(32'h02AAAAAA);
        sh0 = sh_cnt; d0 = done_cnt;
        do_load(w0, w1, 0, 0, 0, gb, hs, tmo);
        total++; if (tmo) begin bad++; $display("FAIL basic_timeout got=1 want=0"); end
        total++; if (sh_cnt - sh0 != 58) begin bad++; $display("FAIL basic_shifts got=%0d want=58", sh_cnt - sh0); end
        total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL basic_done got=%0d want=1", done_cnt - d0); end
        total++; if (chain !== want) begin bad++; $display("FAIL basic_chain got=%h want=%h", chain, want); end
        total++; if (first_sh_cyc - start_cyc != 2) begin bad++; $display("FAIL basic_latency got=%0d want=2", first_sh_cyc - start_cyc); end
        total++; if (rbq.size() != 0) begin bad++; $display("FAIL basic_rb_left got=%0d want=0", rbq.size()); end
        total++; if ({busy, err} !== 2'b00) begin bad++; $display("FAIL basic_idle got=%b want=00", {busy, err}); end
    endtask

    task automatic test_rb_backpressure();
        logic [31:0] w0, w1;
        logic [57:0] want;
        int sh0, d0, gb, hs;
        bit tmo;
        w0 = 32'hDEADBEEF; w1 = 32'h0155_1234;
        want = {w1[25:0], w0};
        preload_chain(PRELOAD);
        rbq.push_back(32'hAAAAAAAA);
        rbq.push_back(32'h02AAAAAA);
        sh0 = sh_cnt; d0 = done_cnt;
        do_load(w0, w1, 0, 40, 0, gb, hs, tmo);
        total++; if (tmo) begin bad++; $display("FAIL bp_timeout got=1 want=0"); end
        total++; if (hs != 26) begin bad++; $display("FAIL bp_shifts_in_hold got=%0d want=26", hs); end
        total++; if (sh_cnt - sh0 != 58) begin bad++; $display("FAIL bp_shifts got=%0d want=58", sh_cnt - sh0); end
        total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL bp_done got=%0d want=1", done_cnt - d0); end
        total++; if (chain !== want) begin bad++; $display("FAIL bp_chain got=%h want=%h", chain, want); end
        total++; if (rbq.size() != 0) begin bad++; $display("FAIL bp_rb_left got=%0d want=0", rbq.size()); end
    endtask

    task automatic test_cfg_gap();
        logic [31:0] w0, w1;
        logic [57:0] want;
        int sh0, d0, gb, hs;
        bit tmo;
        w0 = 32'hDEADBEEF; w1 = 32'h0155_1234;
        want = {w1[25:0], w0};
        preload_chain(PRELOAD);
        rbq.push_back(32'hAAAAAAAA);
        rbq.push_back(32'h02AAAAAA);
        sh0 = sh_cnt; d0 = done_cnt;
        do_load(w0, w1, 5, 0, 0, gb, hs, tmo);
        total++; if (tmo) begin bad++; $display("FAIL gap_timeout got=1 want=0"); end
        total++; if (gb != 0) begin bad++; $display("FAIL gap_fetch_hold got=%0d want=0", gb); end
        total++; if (sh_cnt - sh0 != 58) begin bad++; $display("FAIL gap_shifts got=%0d want=58", sh_cnt - sh0); end
        total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL gap_done got=%0d want=1", done_cnt - d0); end
        total++; if (chain !== want) begin bad++; $display("FAIL gap_chain got=%h want=%h", chain, want); end
        total++; if (rbq.size() != 0) begin bad++; $display("FAIL gap_rb_left got=%0d want=0", rbq.size()); end
    endtask

    task automatic test_abort();
        logic [31:0] w0, w1, v0, v1;
        logic [57:0] init, want;
        int sh0, d0, gb, hs;
        bit tmo;
        w0 = 32'hDEADBEEF; w1 = 32'h0155_1234;
        init = PRELOAD;
        want = {w1[7:0], w0, init[57:40]};
        preload_chain(init);
        rbq.push_back(32'hAAAAAAAA);
        sh0 = sh_cnt; d0 = done_cnt;
        do_load(w0, w1, 0, 0, 40, gb, hs, tmo);
        total++; if (tmo) begin bad++; $display("FAIL abort_timeout got=1 want=0"); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL abort_err got=%b want=1", err); end
        total++; if (done_cnt != d0) begin bad++; $display("FAIL abort_done got=%0d want=0", done_cnt - d0); end
        total++; if (sh_cnt - sh0 != 40) begin bad++; $display("FAIL abort_shifts got=%0d want=40", sh_cnt - sh0); end
        total++; if (chain !== want) begin bad++; $display("FAIL abort_chain got=%h want=%h", chain, want); end
        total++; if (rb_valid !== 1'b0) begin bad++; $display("FAIL abort_rb_valid got=%b want=0", rb_valid); end
        v0 = 32'h1234_5678; v1 = 32'h03C3_A5A5;
        want = {v1[25:0], v0};
        expect_from_chain();
        sh0 = sh_cnt; d0 = done_cnt;
        do_load(v0, v1, 0, 0, 0, gb, hs, tmo);
        total++; if (err !== 1'b0) begin bad++; $display("FAIL abort_err_clear got=%b want=0", err); end
        total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL abort_reload_done got=%0d want=1", done_cnt - d0); end
        total++; if (chain !== want) begin bad++; $display("FAIL abort_reload_chain got=%h want=%h", chain, want); end
    endtask

    task automatic test_reset_mid_load();
        logic [31:0] w0, w1;
        logic [57:0] want;
        int sh0, d0, gb, hs, n;
        bit tmo;
        start = 1'b1; cfg_valid = 1'b1; cfg_data = 32'hFFFF_FFFF;
        @(posedge prog_clk); #1;
        start = 1'b0;
        n = 0;
        @(negedge prog_clk);
        while (!shift_en && n < 50) begin @(negedge prog_clk); n++; end
        #2;
        pReset_n = 1'b0;
        #1;
        total++;
        if ({busy, done, err, cfg_ready, rb_valid, ccff_head, shift_en} !== 7'b0) begin
            bad++;
            $display("FAIL arst_ctrl got=%b want=0000000",
                     {busy, done, err, cfg_ready, rb_valid, ccff_head, shift_en});
        end
        total++;
        if (rb_data !== 32'h0) begin bad++; $display("FAIL arst_rb_data got=%h want=0", rb_data); end
        cfg_valid = 1'b0;
        @(posedge prog_clk); #1;
        pReset_n = 1'b1;
        @(posedge prog_clk); #1;
        w0 = 32'h0F0F_0F0F; w1 = 32'h0288_1771;
        want = {w1[25:0], w0};
        expect_from_chain();
        sh0 = sh_cnt; d0 = done_cnt;
        do_load(w0, w1, 0, 0, 0, gb, hs, tmo);
        total++; if (tmo) begin bad++; $display("FAIL arst_timeout got=1 want=0"); end
        total++; if (sh_cnt - sh0 != 58) begin bad++; $display("FAIL arst_shifts got=%0d want=58", sh_cnt - sh0); end
        total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL arst_done got=%0d want=1", done_cnt - d0); end
        total++; if (chain !== want) begin bad++; $display("FAIL arst_chain got=%h want=%h", chain, want); end
        total++; if (rbq.size() != 0) begin bad++; $display("FAIL arst_rb_left got=%0d want=0", rbq.size()); end
    endtask

    task automatic test_start_collisions();
        logic [31:0] w0, w1;
        logic [57:0] want;
        int sh0, d0, gb, hs;
        bit tmo;
        start = 1'b1; abort = 1'b1;
        @(posedge prog_clk); #1;
        start = 1'b0; abort = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL coll_abort_busy got=%b want=0", busy); end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL coll_abort_err got=%b want=1", err); end
        w0 = 32'h8000_0001; w1 = 32'h02FF_0000;
        want = {w1[25:0], w0};
        expect_from_chain();
        sh0 = sh_cnt; d0 = done_cnt;
        fork
            do_load(w0, w1, 0, 0, 0, gb, hs, tmo);
            begin
                repeat (10) @(posedge prog_clk);
                #1;
                start = 1'b1;
                @(posedge prog_clk); #1;
                start = 1'b0;
            end
        join
        total++; if (tmo) begin bad++; $display("FAIL coll_timeout got=1 want=0"); end
        total++; if (sh_cnt - sh0 != 58) begin bad++; $display("FAIL coll_shifts got=%0d want=58", sh_cnt - sh0); end
        total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL coll_done got=%0d want=1", done_cnt - d0); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL coll_err got=%b want=0", err); end
        total++; if (chain !== want) begin bad++; $display("FAIL coll_chain got=%h want=%h", chain, want); end
        total++; if (rbq.size() != 0) begin bad++; $display("FAIL coll_rb_left got=%0d want=0", rbq.size()); end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_rb_backpressure();
        test_cfg_gap();
        test_abort();
        test_reset_mid_load();
        test_start_collisions();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
